// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment scan arbiter.
// Segment vectors are active-low, ordered {a,b,c,d,e,f,g} with g in bit 0.
package seg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  localparam logic [3:0] CODE_DASH  = 4'hA;
  localparam logic [3:0] CODE_BLANK = 4'hF;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  // Only segment g lit.
  localparam logic [6:0] SEG_DASH  = 7'h7E;

endpackage

// File: rtl/seg7_decode.sv
// Combinational digit-code to active-low segment decoder.
// 0-9 are glyphs, A-E render as a dash, F is blank.
module seg7_decode
  import seg_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_BLANK;
    case (code)
      4'h0: seg_n = 7'b0000001;
      4'h1: seg_n = 7'b1001111;
      4'h2: seg_n = 7'b0010010;
      4'h3: seg_n = 7'b0000110;
      4'h4: seg_n = 7'b1001100;
      4'h5: seg_n = 7'b0100100;
      4'h6: seg_n = 7'b0100000;
      4'h7: seg_n = 7'b0001111;
      4'h8: seg_n = 7'b0000000;
      4'h9: seg_n = 7'b0000100;
      default: begin
        if (code >= CODE_DASH && code < CODE_BLANK) seg_n = SEG_DASH;
        else seg_n = SEG_BLANK;
      end
    endcase
  end

endmodule

// File: rtl/seg_scan_arbiter.sv
// Two-requester arbiter for an 8-digit common-anode display: owns the scan
// timing, grants one requester, and snapshots its digit word once per frame.
module seg_scan_arbiter
  import seg_pkg::*;
#(
  parameter int SCAN_TICKS  = 200_000,
  parameter int HOLD_FRAMES = 63
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [31:0] dig0,
  input  logic [31:0] dig1,
  output logic [1:0]  gnt,
  output logic [7:0]  led_en,
  output logic        led_ca,
  output logic        led_cb,
  output logic        led_cc,
  output logic        led_cd,
  output logic        led_ce,
  output logic        led_cf,
  output logic        led_cg,
  output logic        led_dp
);

  localparam int CNT_W = (SCAN_TICKS > 2) ? $clog2(SCAN_TICKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_TICKS - 1);
  localparam logic [8:0] HOLD_MIN = 9'(HOLD_FRAMES);

  state_t            state_q, state_d;
  logic              rr_q, rr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        pos_q, pos_d;
  logic [7:0]        hold_q, hold_d;
  logic [31:0]       snap_q, snap_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [7:0]        led_en_q, led_en_d;
  logic [6:0]        seg_q, seg_d;

  logic              owner, other, win, hand, go_idle;
  logic              tick_end, frame_end;
  logic [8:0]        hold_inc;
  logic [3:0]        digits [8];
  logic [6:0]        dec_seg;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_digit
      assign digits[gi] = snap_q[4*gi +: 4];
    end
  endgenerate

  seg7_decode u_dec (
    .code  (digits[pos_q]),
    .seg_n (dec_seg)
  );

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    cnt_d    = cnt_q;
    pos_d    = pos_q;
    hold_d   = hold_q;
    snap_d   = snap_q;
    win      = 1'b0;
    hand     = 1'b0;
    go_idle  = 1'b0;
    owner    = (state_q == ST_OWN1);
    other    = ~owner;
    tick_end = (state_q != ST_IDLE) && (cnt_q == CNT_LAST);
    frame_end = tick_end && (pos_q == 3'd7);
    hold_inc = {1'b0, hold_q} + 9'd1;

    case (state_q)
      ST_IDLE: begin
        cnt_d  = '0;
        pos_d  = '0;
        hold_d = '0;
        if (req != 2'b00) begin
          win     = req[rr_q] ? rr_q : ~req[0];
          state_d = win ? ST_OWN1 : ST_OWN0;
          rr_d    = ~win;
          snap_d  = win ? dig1 : dig0;
        end
      end
      default: begin
        cnt_d = tick_end ? '0 : cnt_q + CNT_W'(1);
        if (tick_end) pos_d = pos_q + 3'd1;
        if (frame_end) begin
          snap_d = owner ? dig1 : dig0;
          hold_d = hold_inc[8] ? 8'hFF : hold_inc[7:0];
        end
        // Release beats preemption; the first branch failing implies req[owner].
        if (tick_end && !req[owner]) begin
          if (req[other]) hand = 1'b1;
          else            go_idle = 1'b1;
        end else if (frame_end && req[other] && hold_inc >= HOLD_MIN) begin
          hand = 1'b1;
        end
        if (hand || go_idle) begin
          cnt_d   = '0;
          pos_d   = '0;
          hold_d  = '0;
          state_d = go_idle ? ST_IDLE : (other ? ST_OWN1 : ST_OWN0);
        end
        if (hand) snap_d = other ? dig1 : dig0;
      end
    endcase

    gnt_d    = {state_d == ST_OWN1, state_d == ST_OWN0};
    led_en_d = (state_q == ST_IDLE) ? 8'hFF : ~(8'b1 << pos_q);
    seg_d    = (state_q == ST_IDLE) ? SEG_BLANK : dec_seg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rr_q     <= 1'b0;
      cnt_q    <= '0;
      pos_q    <= '0;
      hold_q   <= '0;
      snap_q   <= 32'hFFFF_FFFF;
      gnt_q    <= 2'b00;
      led_en_q <= 8'hFF;
      seg_q    <= SEG_BLANK;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      cnt_q    <= cnt_d;
      pos_q    <= pos_d;
      hold_q   <= hold_d;
      snap_q   <= snap_d;
      gnt_q    <= gnt_d;
      led_en_q <= led_en_d;
      seg_q    <= seg_d;
    end
  end

  assign gnt    = gnt_q;
  assign led_en = led_en_q;
  assign {led_ca, led_cb, led_cc, led_cd, led_ce, led_cf, led_cg} = seg_q;
  assign led_dp = 1'b1;

endmodule

// File: tb/tb_seg_scan_arbiter.sv
// Self-checking bench for seg_scan_arbiter against a timeline-based reference model.
module tb_seg_scan_arbiter;

  localparam int ST = 4;
  localparam int HF = 2;
  localparam int FRAME = 8 * ST;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = 2'b00;
  logic [31:0] dig0 = 32'hFFFF_FFFF;
  logic [31:0] dig1 = 32'hFFFF_FFFF;
  logic [1:0]  gnt;
  logic [7:0]  led_en;
  logic        led_ca, led_cb, led_cc, led_cd, led_ce, led_cf, led_cg, led_dp;
  logic [6:0]  seg_obs;

  int total = 0;
  int bad   = 0;

  // Model: owner (-1 idle), cycles elapsed since ownership began, snapshot, rr.
  int          m_own  = -1;
  int          m_el   = 0;
  int          m_rr   = 0;
  logic [31:0] m_snap = 32'hFFFF_FFFF;
  logic [1:0]  exp_gnt = 2'b00;
  logic [7:0]  exp_en  = 8'hFF;
  logic [6:0]  exp_seg = 7'h7F;

  seg_scan_arbiter #(.SCAN_TICKS(ST), .HOLD_FRAMES(HF)) dut (
    .clk(clk), .rst(rst), .req(req), .dig0(dig0), .dig1(dig1), .gnt(gnt),
    .led_en(led_en), .led_ca(led_ca), .led_cb(led_cb), .led_cc(led_cc),
    .led_cd(led_cd), .led_ce(led_ce), .led_cf(led_cf), .led_cg(led_cg),
    .led_dp(led_dp)
  );

  assign seg_obs = {led_ca, led_cb, led_cc, led_cd, led_ce, led_cf, led_cg};

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input logic [3:0] c);
    case (c)
      4'd0: return 7'b0000001;
      4'd1: return 7'b1001111;
      4'd2: return 7'b0010010;
      4'd3: return 7'b0000110;
      4'd4: return 7'b1001100;
      4'd5: return 7'b0100100;
      4'd6: return 7'b0100000;
      4'd7: return 7'b0001111;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0000100;
      4'hF: return 7'b1111111;
      default: return 7'b1111110;
    endcase
  endfunction

  function automatic int m_slot();
    return (m_el / ST) % 8;
  endfunction

  // Advance model by one clock using the inputs the DUT is about to sample.
  task automatic tick();
    int x, o, slot, frames;
    bit te, fe;
    if (m_own < 0) begin
      exp_en  = 8'hFF;
      exp_seg = 7'h7F;
    end else begin
      slot    = m_slot();
      exp_en  = ~(8'd1 << slot);
      exp_seg = glyph(m_snap[4*slot +: 4]);
    end
    if (rst) begin
      exp_en  = 8'hFF;
      exp_seg = 7'h7F;
      m_own   = -1;
      m_rr    = 0;
      m_el    = 0;
      m_snap  = 32'hFFFF_FFFF;
    end else if (m_own < 0) begin
      if (req != 2'b00) begin
        x      = req[m_rr] ? m_rr : (req[0] ? 0 : 1);
        m_own  = x;
        m_rr   = 1 - x;
        m_snap = (x == 1) ? dig1 : dig0;
        m_el   = 0;
      end
    end else begin
      x      = m_own;
      o      = 1 - x;
      te     = (m_el % ST) == ST - 1;
      fe     = (m_el % FRAME) == FRAME - 1;
      frames = m_el / FRAME + 1;
      if (te && !req[x]) begin
        m_el = 0;
        if (req[o]) begin
          m_own  = o;
          m_snap = (o == 1) ? dig1 : dig0;
        end else begin
          m_own = -1;
        end
      end else if (fe && req[o] && frames >= HF) begin
        m_own  = o;
        m_snap = (o == 1) ? dig1 : dig0;
        m_el   = 0;
      end else begin
        if (fe) m_snap = (x == 1) ? dig1 : dig0;
        m_el++;
      end
    end
    exp_gnt = (m_own == 0) ? 2'b01 : (m_own == 1) ? 2'b10 : 2'b00;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    total += 4;
    if (gnt !== 2'b00) begin bad++; $display("FAIL reset_gnt got=%b exp=00", gnt); end
    if (led_en !== 8'hFF) begin bad++; $display("FAIL reset_en got=%h exp=FF", led_en); end
    if (seg_obs !== 7'h7F) begin bad++; $display("FAIL reset_seg got=%b exp=1111111", seg_obs); end
    if (led_dp !== 1'b1) begin bad++; $display("FAIL reset_dp got=%b exp=1", led_dp); end
    rst = 1'b0;
    req = 2'b00;
    for (int i = 0; i < 100; i++) begin
      tick();
      total += 3;
      if (gnt !== exp_gnt) begin bad++; $display("FAIL idle_gnt cyc=%0d got=%b exp=%b", i, gnt, exp_gnt); end
      if (led_en !== exp_en) begin bad++; $display("FAIL idle_en cyc=%0d got=%h exp=%h", i, led_en, exp_en); end
      if (seg_obs !== exp_seg) begin bad++; $display("FAIL idle_seg cyc=%0d got=%b exp=%b", i, seg_obs, exp_seg); end
    end
    $display("test_reset done total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_scan();
    dig0 = 32'h7654_3210;
    req  = 2'b01;
    tick();
    total++;
    if (gnt !== 2'b01) begin bad++; $display("FAIL scan_grant got=%b exp=01", gnt); end
    tick();
    total += 2;
    if (led_en !== 8'hFE) begin bad++; $display("FAIL scan_slot0_en got=%h exp=FE", led_en); end
    if (seg_obs !== 7'b0000001) begin bad++; $display("FAIL scan_slot0_seg got=%b exp=0000001", seg_obs); end
    for (int i = 0; i < 62; i++) begin
      tick();
      total += 3;
      if (gnt !== exp_gnt) begin bad++; $display("FAIL scan_gnt cyc=%0d got=%b exp=%b", i, gnt, exp_gnt); end
      if (led_en !== exp_en) begin bad++; $display("FAIL scan_en cyc=%0d got=%h exp=%h", i, led_en, exp_en); end
      if (seg_obs !== exp_seg) begin bad++; $display("FAIL scan_seg cyc=%0d got=%b exp=%b", i, seg_obs, exp_seg); end
    end
    $display("test_scan done total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_preempt();
    bit seen = 0;
    dig1 = $urandom & 32'h9999_9999;
    req  = 2'b11;
    for (int i = 0; i < 120; i++) begin
      tick();
      if (gnt === 2'b10) seen = 1;
      total += 3;
      if (gnt !== exp_gnt) begin bad++; $display("FAIL pre_gnt cyc=%0d got=%b exp=%b", i, gnt, exp_gnt); end
      if (led_en !== exp_en) begin bad++; $display("FAIL pre_en cyc=%0d got=%h exp=%h", i, led_en, exp_en); end
      if (seg_obs !== exp_seg) begin bad++; $display("FAIL pre_seg cyc=%0d got=%b exp=%b", i, seg_obs, exp_seg); end
    end
    total++;
    if (!seen) begin bad++; $display("FAIL pre_handover got=none exp=gnt10 within 120 cycles"); end
    req = 2'b00;
    for (int i = 0; i < 20; i++) begin
      tick();
      total += 3;
      if (gnt !== exp_gnt) begin bad++; $display("FAIL rel_gnt cyc=%0d got=%b exp=%b", i, gnt, exp_gnt); end
      if (led_en !== exp_en) begin bad++; $display("FAIL rel_en cyc=%0d got=%h exp=%h", i, led_en, exp_en); end
      if (seg_obs !== exp_seg) begin bad++; $display("FAIL rel_seg cyc=%0d got=%b exp=%b", i, seg_obs, exp_seg); end
    end
    $display("test_preempt done total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_simultaneous();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 2'b11;
    tick();
    total++;
    if (gnt !== 2'b01) begin bad++; $display("FAIL simul_first got=%b exp=01", gnt); end
    req = 2'b00;
    for (int i = 0; i < 20; i++) begin
      tick();
      total += 3;
      if (gnt !== exp_gnt) begin bad++; $display("FAIL simul_gnt cyc=%0d got=%b exp=%b", i, gnt, exp_gnt); end
      if (led_en !== exp_en) begin bad++; $display("FAIL simul_en cyc=%0d got=%h exp=%h", i, led_en, exp_en); end
      if (seg_obs !== exp_seg) begin bad++; $display("FAIL simul_seg cyc=%0d got=%b exp=%b", i, seg_obs, exp_seg); end
    end
    req = 2'b11;
    tick();
    total++;
    if (gnt !== 2'b10) begin bad++; $display("FAIL simul_second got=%b exp=10", gnt); end
    req = 2'b00;
    for (int i = 0; i < 10; i++) tick();
    $display("test_simultaneous done total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_snapshot();
    bit found = 0;
    rst = 1'b1;
    tick();
    rst  = 1'b0;
    dig0 = 32'h1111_1111;
    req  = 2'b01;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      if (m_own == 0 && m_slot() == 3) found = 1;
    end
    total++;
    if (!found) begin bad++; $display("FAIL snap_reach_slot3 got=timeout exp=slot3"); end
    dig0 = 32'h2222_2222;
    for (int i = 0; i < 80; i++) begin
      tick();
      total += 3;
      if (gnt !== exp_gnt) begin bad++; $display("FAIL snap_gnt cyc=%0d got=%b exp=%b", i, gnt, exp_gnt); end
      if (led_en !== exp_en) begin bad++; $display("FAIL snap_en cyc=%0d got=%h exp=%h", i, led_en, exp_en); end
      if (seg_obs !== exp_seg) begin bad++; $display("FAIL snap_seg cyc=%0d got=%b exp=%b", i, seg_obs, exp_seg); end
    end
    dig0 = 32'hFFFF_FAFF;
    for (int i = 0; i < 80; i++) begin
      tick();
      total += 3;
      if (gnt !== exp_gnt) begin bad++; $display("FAIL dash_gnt cyc=%0d got=%b exp=%b", i, gnt, exp_gnt); end
      if (led_en !== exp_en) begin bad++; $display("FAIL dash_en cyc=%0d got=%h exp=%h", i, led_en, exp_en); end
      if (seg_obs !== exp_seg) begin bad++; $display("FAIL dash_seg cyc=%0d got=%b exp=%b", i, seg_obs, exp_seg); end
    end
    $display("test_snapshot done total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_rst_mid();
    bit found = 0;
    rst = 1'b1;
    tick();
    rst  = 1'b0;
    dig1 = $urandom & 32'h7777_7777;
    req  = 2'b10;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      if (m_own == 1 && m_slot() == 5) found = 1;
    end
    total++;
    if (!found) begin bad++; $display("FAIL rstmid_reach_slot5 got=timeout exp=slot5"); end
    rst = 1'b1;
    tick();
    total += 3;
    if (gnt !== 2'b00) begin bad++; $display("FAIL rstmid_gnt got=%b exp=00", gnt); end
    if (led_en !== 8'hFF) begin bad++; $display("FAIL rstmid_en got=%h exp=FF", led_en); end
    if (seg_obs !== 7'h7F) begin bad++; $display("FAIL rstmid_seg got=%b exp=1111111", seg_obs); end
    rst = 1'b0;
    tick();
    total++;
    if (gnt !== 2'b10) begin bad++; $display("FAIL rstmid_regrant got=%b exp=10", gnt); end
    $display("test_rst_mid done total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) req = 2'($urandom);
      if ($urandom_range(3) == 0) dig0 = $urandom;
      if ($urandom_range(3) == 0) dig1 = $urandom;
      rst = ($urandom_range(499) == 0);
      tick();
      total += 3;
      if (gnt !== exp_gnt) begin bad++; $display("FAIL rnd_gnt cyc=%0d got=%b exp=%b", i, gnt, exp_gnt); end
      if (led_en !== exp_en) begin bad++; $display("FAIL rnd_en cyc=%0d got=%h exp=%h", i, led_en, exp_en); end
      if (seg_obs !== exp_seg) begin bad++; $display("FAIL rnd_seg cyc=%0d got=%b exp=%b", i, seg_obs, exp_seg); end
    end
    rst = 1'b0;
    $display("test_random done total=%0d bad=%0d", total, bad);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_scan();
    test_preempt();
    test_simultaneous();
    test_snapshot();
    test_rst_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
